// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the ICache read port, and
// freezes the pipeline on ICache misses. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_Sel,
  input  logic [31:0] alu_target,
  input  logic        Inst_Kill,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic [31:0] icache_dout,
  input  logic        icache_stall,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_I,
  output logic [31:0] pc_X,
  output logic        fetch_stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
  localparam logic [1:0] PCSEL_ALU   = 2'd1;

  localparam logic [1:0] S_BOOT       = 2'd0;
  localparam logic [1:0] S_RUN        = 2'd1;
  localparam logic [1:0] S_MISS       = 2'd2;
  localparam logic [1:0] S_MISS_REDIR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_i_q, pc_i_d;
  logic [31:0] pc_x_q, pc_x_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        redirect;
  logic [31:0] tgt;
  logic [31:0] npc;
  logic [31:0] redir_tgt;

  assign redirect  = (PC_Sel == PCSEL_ALU);
  assign tgt       = alu_target & 32'hFFFF_FFFC;
  assign npc       = redirect ? tgt : (pc_i_q + 32'd4);
  // A redirect arriving in the same cycle the miss resolves beats the older pending one.
  assign redir_tgt = redirect ? tgt : pend_tgt_q;

  // Handshake: inst_valid=1 means inst/pc_I carry a real fetched word this cycle
  // and the pipeline advances; fetch_stall=1 means nothing downstream may advance.
  always_comb begin
    state_d     = state_q;
    pc_i_d      = pc_i_q;
    pc_x_d      = pc_x_q;
    pend_tgt_d  = pend_tgt_q;
    icache_addr = pc_i_q;
    inst_valid  = 1'b0;
    fetch_stall = 1'b0;
    case (state_q)
      S_BOOT: begin
        icache_addr = RESET_PC;
        pc_i_d      = RESET_PC;
        state_d     = S_RUN;
      end
      S_RUN: begin
        icache_addr = npc;
        if (icache_stall) begin
          fetch_stall = 1'b1;
          if (redirect) begin
            pend_tgt_d = tgt;
            state_d    = S_MISS_REDIR;
          end else begin
            state_d = S_MISS;
          end
        end else begin
          inst_valid = 1'b1;
          pc_x_d     = pc_i_q;
          pc_i_d     = npc;
        end
      end
      S_MISS: begin
        fetch_stall = 1'b1;
        if (redirect) begin
          pend_tgt_d = tgt;
          state_d    = S_MISS_REDIR;
        end else if (!icache_stall) begin
          state_d = S_RUN;
        end
      end
      S_MISS_REDIR: begin
        fetch_stall = 1'b1;
        if (redirect) pend_tgt_d = tgt;
        if (!icache_stall) begin
          icache_addr = redir_tgt;
          pc_i_d      = redir_tgt;
          state_d     = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      pc_i_q     <= RESET_PC;
      pc_x_q     <= 32'd0;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_i_q     <= pc_i_d;
      pc_x_q     <= pc_x_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign icache_re   = 1'b1;
  assign inst        = (inst_valid && !Inst_Kill) ? icache_dout : NOP_INST;
  assign pc_I        = pc_i_q;
  assign pc_X        = pc_x_q;
  assign dbg_state_o = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (inst_valid && !Inst_Kill && !fetch_stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (fetch_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ICache, expected-PC scoreboard and a
// negedge monitor checking the delivered instruction stream and stall timing.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_2000;
  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [1:0]  PCSEL_PLUS4 = 2'd0;
  localparam logic [1:0]  PCSEL_ALU   = 2'd1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  PC_Sel = PCSEL_PLUS4;
  logic [31:0] alu_target = 32'd0;
  logic        Inst_Kill = 1'b0;
  logic [31:0] icache_dout = 32'd0;
  logic        icache_stall = 1'b0;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc_I;
  logic [31:0] pc_X;
  logic        fetch_stall;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [1:0]  dbg_state_o;

  fetch_unit dut (
    .clk(clk), .reset(reset), .PC_Sel(PC_Sel), .alu_target(alu_target),
    .Inst_Kill(Inst_Kill), .icache_addr(icache_addr), .icache_re(icache_re),
    .icache_dout(icache_dout), .icache_stall(icache_stall), .inst(inst),
    .inst_valid(inst_valid), .pc_I(pc_I), .pc_X(pc_X), .fetch_stall(fetch_stall),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .dbg_state_o(dbg_state_o)
  );

  int checks = 0;
  int failures = 0;

  // scoreboard: PC of the next instruction the fetch unit must deliver
  logic [31:0] exp_q[$];
  logic [31:0] last_pc = 32'd0;
  logic [31:0] addr_prev = RESET_PC;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic        boot_cyc = 1'b0;
  int unsigned exp_fetch = 0;
  int unsigned exp_stall = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of controller + ICache stimulus, applied #1 after posedge
  task automatic do_cycle(input logic redir, input logic [31:0] tgt,
                          input logic kill, input logic stall);
    logic r;
    logic s;
    r = boot_cyc ? 1'b0 : redir;
    s = boot_cyc ? 1'b0 : stall;
    PC_Sel       = r ? PCSEL_ALU : PCSEL_PLUS4;
    alu_target   = r ? tgt : $urandom;
    Inst_Kill    = kill;
    icache_stall = s;
    icache_dout  = s ? $urandom : mem_word(addr_prev);
    @(posedge clk);
    #1;
    boot_cyc = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b0;
    PC_Sel       = PCSEL_PLUS4;
    Inst_Kill    = 1'b0;
    icache_stall = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset    = 1'b1;
    boot_cyc = 1'b1;
    do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // monitor: samples on the falling edge
  logic        m_redir;
  logic [31:0] m_tgt;
  logic [31:0] m_e;
  logic [31:0] m_next;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_pc_I", pc_I, RESET_PC);
        chk("rst_pc_X", pc_X, 32'd0);
        chk("rst_inst", inst, NOP);
        chk1("rst_valid", inst_valid, 1'b0);
        chk1("rst_fstall", fetch_stall, 1'b0);
        chk1("rst_re", icache_re, 1'b1);
        chk("rst_addr", icache_addr, RESET_PC);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        last_pc    = 32'd0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        exp_fetch  = 0;
        exp_stall  = 0;
        addr_prev  = icache_addr;
      end else begin
        m_redir = (PC_Sel == PCSEL_ALU);
        m_tgt   = alu_target & 32'hFFFF_FFFC;
        chk1("icache_re", icache_re, 1'b1);
        chk("addr_align", {30'd0, icache_addr[1:0]}, 32'd0);
        if (boot_cyc) begin
          chk1("boot_valid", inst_valid, 1'b0);
          chk1("boot_fstall", fetch_stall, 1'b0);
          chk("boot_addr", icache_addr, RESET_PC);
        end else begin
          chk1("fstall_vs_valid", fetch_stall, !inst_valid);
          if (icache_stall || prev_stall) chk1("valid_in_miss", inst_valid, 1'b0);
          else if (!prev_redir) chk1("valid_expected", inst_valid, 1'b1);
        end
        if (inst_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL deliver_unexpected actual=%h required=none", pc_I);
          end else begin
            m_e    = exp_q.pop_front();
            m_next = m_redir ? m_tgt : m_e + 32'd4;
            chk("pc_I", pc_I, m_e);
            chk("pc_X", pc_X, last_pc);
            chk("inst", inst, Inst_Kill ? NOP : mem_word(m_e));
            chk("next_addr", icache_addr, m_next);
            last_pc = m_e;
            exp_q.push_back(m_next);
          end
        end else begin
          chk("inst_bubble", inst, NOP);
          if (m_redir && !boot_cyc) begin
            exp_q.delete();
            exp_q.push_back(m_tgt);
          end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, exp_fetch);
        chk("perf_stall", perf_stall_cnt, exp_stall);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 32'd0);
        chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
        if (inst_valid && !Inst_Kill) exp_fetch++;
        if (!boot_cyc && !inst_valid) exp_stall++;
        prev_stall = icache_stall && !boot_cyc;
        prev_redir = m_redir && !boot_cyc;
        addr_prev  = icache_addr;
      end
    end
  end

  // stimulus
  initial begin
    logic        r;
    logic        k;
    logic        s;
    logic [31:0] t;
    @(posedge clk);
    #1;
    do_reset(2);
    repeat (2) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 32'h0000_3001, 1'b1, 1'b0);
    repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    do_cycle(1'b1, 32'h0000_4000, 1'b0, 1'b1);
    do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    do_reset(3);
    repeat (10) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) do_cycle(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (4) do_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (4000) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        r = ($urandom_range(0, 7) == 0);
        k = ($urandom_range(0, 7) == 0);
        s = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else t = $urandom;
        do_cycle(r, t, k, s);
      end
    end
    $display("final fetch state %0d", dbg_state_o);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
